decode_rp_arbiter: RTL and testbench
====================================

// Module: decode_rp_arbiter
// PURPOSE
//  Shares one decode_rp instance between two requesters: req0 = public-key decode, req1 = ciphertext decode.
//  Arbitrates round-robin, issues the decoder start pulse and drives dec_cfg_sel to the top-level param ROM mux.
//  Routes decoder byte-read and coefficient-write ports to the granted requester's memories.
//  Signals completion after the decoder's final writes have drained.
// PARAMETERS
//  OUT_DEPTH   `OUT_DEPTH   byte-memory address width
//  OUT_D_SIZE  `OUT_D_SIZE  byte-memory data width
//  RP_DEPTH    `RP_DEPTH    coefficient-memory address width
//  RP_D_SIZE   `RP_D_SIZE   coefficient data width
//  DRAIN_CYC   4            cycles in DRAIN after dec_done before reqN_done (1..15)
//  WDOG_CYC    65535        RUN-cycle limit; used only with DECODE_ARB_WDOG_EN
// PORTS
//  clk            in   1           clock, rising edge
//  rst_n          in   1           asynchronous active-low reset
//  req_valid      in   2           [i]: requester i wants a decode; held until req_done[i]
//  req_grant      out  2           one-hot; high from GRANT through DONE
//  req_done       out  2           1-cycle completion pulse
//  req_err        out  2           1-cycle watchdog-abort pulse, coincident with req_done
//  dec_start      out  1           decoder start pulse
//  dec_done       in   1           decoder done
//  dec_cfg_sel    out  1           param-set select; 0 = pk, 1 = ct
//  dec_rd_addr    in   OUT_DEPTH   decoder byte-read address
//  dec_rd_data    out  OUT_D_SIZE  muxed byte-read data
//  dec_wr_addr    in   RP_DEPTH    decoder coefficient-write address
//  dec_wr_data    in   RP_D_SIZE   decoder coefficient-write data
//  dec_wr_en      in   1           decoder write enable
//  mN_rd_addr     out  OUT_DEPTH   N = 0,1; dec_rd_addr when granted, else 0
//  mN_rd_data     in   OUT_D_SIZE  1-cycle-latency memory read data
//  mN_wr_addr     out  RP_DEPTH    dec_wr_addr when granted, else 0
//  mN_wr_data     out  RP_D_SIZE   dec_wr_data when granted, else 0
//  mN_wr_en       out  1           dec_wr_en AND granted to N
// BEHAVIOUR
//  - Reset: all outputs 0; FSM = IDLE; last_served = 1, so req0 wins the first tie. Counters cleared.
//  - Reset mid-run aborts at once. No done or err is issued.
//    The decoder has no reset, so the next GRANT's dec_start reinitialises it.
//  - FSM, one register:
//    IDLE -> GRANT when any req_valid. Winner = sole requester; on a tie, the one != last_served.
//    GRANT (1 cyc): latch winner as sel; req_grant[sel]=1; dec_cfg_sel=sel; dec_start=1.
//    RUN: wait for dec_done=1, sampled from the cycle after GRANT (a stale done is ignored) -> DRAIN.
//    DRAIN: count DRAIN_CYC cycles; writes still forwarded -> DONE.
//    DONE (1 cyc): req_done[sel]=1; last_served <= sel -> IDLE.
//    Grant stays asserted in DONE, and req_valid is next sampled in IDLE.
//    Minimum spacing between back-to-back jobs is therefore 1 IDLE cycle.
//  - sel and dec_cfg_sel are stable from GRANT to DONE. dec_cfg_sel holds its last value in IDLE.
//  - Read mux: dec_rd_data = mSEL_rd_data, selected by a registered sel, so memory latency is preserved.
//    Read mux output is 0 in IDLE.
//  - Address/write routing is combinational from dec_* ports: zero added latency.
//    The non-granted memory sees en = 0 and addr/data = 0.
//  - req_valid dropped before done: ignored; the job completes.
//    req_valid[sel] still high in IDLE after done: treated as a new request, subject to fairness.
//  - dec_done outside RUN: ignored.
//  - Cycle counter: 16-bit, cleared at GRANT, incremented in RUN, saturates at 0xFFFF.
// CONFIGURATION
//  DECODE_ARB_WDOG_EN defined:
//    - If the RUN counter reaches WDOG_CYC, go RUN -> DONE, skipping DRAIN.
//    - In DONE, pulse req_err[sel] and req_done[sel] together; mN_wr_en is forced 0 in that DONE.
//  DECODE_ARB_WDOG_EN undefined:
//    - req_err is tied 0; RUN waits indefinitely; WDOG_CYC is unused.
// TESTING
//  1. req_valid=01 -> dec_start pulses, dec_cfg_sel=0. dec_done at RUN+100 -> req_done[0] exactly 4+1 cycles later.
//  2. req_valid=11 from reset -> req0 served, then req1, then req0; each req_done one-hot.
//  3. During grant to 1, dec_wr_en=1, addr=5, data=0x123 -> m1 written; m0_wr_en stays 0.
//     m1_rd_data follows dec_rd_addr with 1 cycle latency.
//  4. Assert rst_n=0 in RUN -> all outputs 0 next edge; a new req then issues dec_start normally.
//  5. dec_done=1 in IDLE and GRANT -> ignored; RUN still waits for a fresh dec_done.
//  6. WDOG_EN, WDOG_CYC=50, no dec_done -> req_err[sel] and req_done[sel] at RUN+50; without the macro, no completion.

Source files
------------

// File: rtl/decode_rp_arbiter_if.sv
// ============================================================================
// Module : decode_rp_arbiter_if
// Brief  : Requester, decoder and memory bus shared by the decode_rp arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef OUT_DEPTH
`define OUT_DEPTH 8
`endif
`ifndef OUT_D_SIZE
`define OUT_D_SIZE 8
`endif
`ifndef RP_DEPTH
`define RP_DEPTH 8
`endif
`ifndef RP_D_SIZE
`define RP_D_SIZE 12
`endif

interface decode_rp_arbiter_if #(
    parameter int OUT_DEPTH  = `OUT_DEPTH,
    parameter int OUT_D_SIZE = `OUT_D_SIZE,
    parameter int RP_DEPTH   = `RP_DEPTH,
    parameter int RP_D_SIZE  = `RP_D_SIZE
);
    logic [1:0]            req_valid;
    logic [1:0]            req_grant;
    logic [1:0]            req_done;
    logic [1:0]            req_err;
    logic                  dec_start;
    logic                  dec_done;
    logic                  dec_cfg_sel;
    logic [OUT_DEPTH-1:0]  dec_rd_addr;
    logic [OUT_D_SIZE-1:0] dec_rd_data;
    logic [RP_DEPTH-1:0]   dec_wr_addr;
    logic [RP_D_SIZE-1:0]  dec_wr_data;
    logic                  dec_wr_en;
    logic [OUT_DEPTH-1:0]  m0_rd_addr;
    logic [OUT_D_SIZE-1:0] m0_rd_data;
    logic [RP_DEPTH-1:0]   m0_wr_addr;
    logic [RP_D_SIZE-1:0]  m0_wr_data;
    logic                  m0_wr_en;
    logic [OUT_DEPTH-1:0]  m1_rd_addr;
    logic [OUT_D_SIZE-1:0] m1_rd_data;
    logic [RP_DEPTH-1:0]   m1_wr_addr;
    logic [RP_D_SIZE-1:0]  m1_wr_data;
    logic                  m1_wr_en;

    modport master (
        input  req_valid, dec_done, dec_rd_addr, dec_wr_addr, dec_wr_data, dec_wr_en,
               m0_rd_data, m1_rd_data,
        output req_grant, req_done, req_err, dec_start, dec_cfg_sel, dec_rd_data,
               m0_rd_addr, m0_wr_addr, m0_wr_data, m0_wr_en,
               m1_rd_addr, m1_wr_addr, m1_wr_data, m1_wr_en
    );

    modport slave (
        output req_valid, dec_done, dec_rd_addr, dec_wr_addr, dec_wr_data, dec_wr_en,
               m0_rd_data, m1_rd_data,
        input  req_grant, req_done, req_err, dec_start, dec_cfg_sel, dec_rd_data,
               m0_rd_addr, m0_wr_addr, m0_wr_data, m0_wr_en,
               m1_rd_addr, m1_wr_addr, m1_wr_data, m1_wr_en
    );
endinterface

`default_nettype wire

// File: rtl/decode_rp_arbiter.sv
// ============================================================================
// Module : decode_rp_arbiter
// Brief  : Round-robin sharing of one decode_rp between pk and ct requesters.
//          Optional RUN watchdog enabled by macro DECODE_ARB_WDOG_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module decode_rp_arbiter #(
    parameter int DRAIN_CYC = 4,
    parameter int WDOG_CYC  = 65535
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    decode_rp_arbiter_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        sel;
    logic        last_served;
    logic        winner;
    logic [15:0] run_cnt;
    logic [3:0]  drain_cnt;
    logic        wdog_hit;
    logic        abort;
    logic        granted;
    logic        g0;
    logic        g1;
    logic        wr_ok;
    logic [1:0]  sel_vec;

`ifdef DECODE_ARB_WDOG_EN
    assign wdog_hit = (run_cnt >= 16'(WDOG_CYC - 1));

    // Remembers that the coming DONE was reached by timeout rather than DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abort <= 1'b0;
        end else begin
            abort <= (state == ST_RUN) && !bus.dec_done && wdog_hit;
        end
    end
`else
    logic [15:0] unused_wdog;
    assign unused_wdog = 16'(WDOG_CYC);
    assign wdog_hit    = 1'b0;
    assign abort       = 1'b0;
`endif

    always_comb begin
        if (bus.req_valid == 2'b11) begin
            winner = ~last_served;
        end else begin
            winner = bus.req_valid[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            sel         <= 1'b0;
            last_served <= 1'b1;
            run_cnt     <= '0;
            drain_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && (|bus.req_valid)) begin
                sel <= winner;
            end
            if (state == ST_DONE) begin
                last_served <= sel;
            end
            if (state == ST_GRANT) begin
                run_cnt <= '0;
            end else if (state == ST_RUN && run_cnt != 16'hFFFF) begin
                run_cnt <= run_cnt + 16'd1;
            end
            if (state == ST_DRAIN) begin
                drain_cnt <= drain_cnt + 4'd1;
            end else begin
                drain_cnt <= '0;
            end
        end
    end

    assign sel_vec = {sel, ~sel};

    always_comb begin
        state_nxt     = state;
        granted       = (state != ST_IDLE);
        bus.dec_start = 1'b0;
        bus.req_grant = 2'b00;
        bus.req_done  = 2'b00;
        bus.req_err   = 2'b00;
        case (state)
            ST_IDLE: begin
                if (|bus.req_valid) begin
                    state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                bus.dec_start = 1'b1;
                state_nxt     = ST_RUN;
            end
            ST_RUN: begin
                if (bus.dec_done) begin
                    state_nxt = ST_DRAIN;
                end else if (wdog_hit) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == 4'(DRAIN_CYC - 1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.req_done = sel_vec;
                bus.req_err  = abort ? sel_vec : 2'b00;
                state_nxt    = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (granted) begin
            bus.req_grant = sel_vec;
        end
    end

    assign g0    = granted & ~sel;
    assign g1    = granted &  sel;
    assign wr_ok = !(abort && state == ST_DONE);

    assign bus.dec_cfg_sel = sel;
    // sel is registered, so the mux adds nothing to the memory's read latency.
    assign bus.dec_rd_data = !granted ? '0 : (sel ? bus.m1_rd_data : bus.m0_rd_data);

    assign bus.m0_rd_addr = g0 ? bus.dec_rd_addr : '0;
    assign bus.m0_wr_addr = g0 ? bus.dec_wr_addr : '0;
    assign bus.m0_wr_data = g0 ? bus.dec_wr_data : '0;
    assign bus.m0_wr_en   = bus.dec_wr_en & g0 & wr_ok;
    assign bus.m1_rd_addr = g1 ? bus.dec_rd_addr : '0;
    assign bus.m1_wr_addr = g1 ? bus.dec_wr_addr : '0;
    assign bus.m1_wr_data = g1 ? bus.dec_wr_data : '0;
    assign bus.m1_wr_en   = bus.dec_wr_en & g1 & wr_ok;

endmodule

`default_nettype wire

// File: tb/tb_decode_rp_arbiter.sv
// ============================================================================
// Module : tb_decode_rp_arbiter
// Brief  : Directed self-checking bench for decode_rp_arbiter with a done scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_decode_rp_arbiter;

    localparam int DRAIN_CYC = 4;
    localparam int WDOG_CYC  = 50;
`ifdef DECODE_ARB_WDOG_EN
    localparam int RUN_LEN = 30;
`else
    localparam int RUN_LEN = 100;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    decode_rp_arbiter_if #(.OUT_DEPTH(8), .OUT_D_SIZE(8), .RP_DEPTH(8), .RP_D_SIZE(12)) bus ();

    decode_rp_arbiter #(.DRAIN_CYC(DRAIN_CYC), .WDOG_CYC(WDOG_CYC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [7:0] f0(input logic [7:0] a);
        return a ^ 8'hA5;
    endfunction

    function automatic logic [7:0] f1(input logic [7:0] a);
        return a + 8'h3C;
    endfunction

    // 1-cycle-latency read memories
    always @(posedge clk) begin
        bus.m0_rd_data <= f0(bus.m0_rd_addr);
        bus.m1_rd_data <= f1(bus.m1_rd_addr);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(input logic [1:0] grant);
        int k = 0;
        do begin
            tick();
            k++;
        end while (bus.dec_start !== 1'b1 && k < 10);
        check("dec_start", {31'd0, bus.dec_start}, 32'd1);
        check("grant_at_start", {30'd0, bus.req_grant}, {30'd0, grant});
        check("cfg_sel", {31'd0, bus.dec_cfg_sel}, {31'd0, grant[1]});
    endtask

    task automatic wait_done(input int k0, input int exp_lat, input int budget);
        int k = k0;
        logic [3:0] exp;
        while (bus.req_done === 2'b00 && k < budget) begin
            tick();
            k++;
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hF;
        if (bus.req_done === 2'b00) begin
            check("done_timeout", {30'd0, bus.req_done}, {30'd0, exp[1:0]});
        end else begin
            check("done_latency", k, exp_lat);
            check("done_err", {28'd0, bus.req_err, bus.req_done}, {28'd0, exp});
        end
    endtask

    task automatic finish_job(input logic [1:0] grant);
        bus.dec_done = 1'b1;
        exp_q.push_back({2'b00, grant});
        tick();
        bus.dec_done = 1'b0;
        wait_done(1, DRAIN_CYC + 1, 20);
    endtask

    initial begin
        logic [1:0] seen;
        bus.req_valid   = 2'b00;
        bus.dec_done    = 1'b0;
        bus.dec_rd_addr = '0;
        bus.dec_wr_addr = '0;
        bus.dec_wr_data = '0;
        bus.dec_wr_en   = 1'b0;
        tick();
        tick();
        check("rst_grant", {30'd0, bus.req_grant}, 32'd0);
        check("rst_done", {30'd0, bus.req_done}, 32'd0);
        check("rst_start", {31'd0, bus.dec_start}, 32'd0);
        check("rst_cfg", {31'd0, bus.dec_cfg_sel}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Tie from reset: 0, 1, 0
        bus.req_valid = 2'b11;
        wait_start(2'b01);
        tick();
        tick();
        finish_job(2'b01);
        tick();
        check("idle_gap_start", {31'd0, bus.dec_start}, 32'd0);
        check("idle_gap_grant", {30'd0, bus.req_grant}, 32'd0);
        wait_start(2'b10);
        tick();
        finish_job(2'b10);
        wait_start(2'b01);
        tick();
        finish_job(2'b01);
        bus.req_valid = 2'b00;
        tick();

        // Single pk request with a long RUN
        bus.req_valid = 2'b01;
        bus.dec_rd_addr = 8'h11;
        wait_start(2'b01);
        tick();
        check("run_start_low", {31'd0, bus.dec_start}, 32'd0);
        bus.req_valid = 2'b00;
        repeat (RUN_LEN - 1) tick();
        check("run_grant_held", {30'd0, bus.req_grant}, 32'd1);
        finish_job(2'b01);
        tick();
        check("idle_rd_data", {24'd0, bus.dec_rd_data}, 32'd0);

        // Stale done in IDLE and GRANT, plus write/read routing to m1
        bus.req_valid = 2'b10;
        bus.dec_done  = 1'b1;
        wait_start(2'b10);
        bus.dec_done = 1'b0;
        repeat (10) tick();
        check("stale_done_ignored", {30'd0, bus.req_grant, bus.req_done}, 32'h8);
        bus.dec_wr_en   = 1'b1;
        bus.dec_wr_addr = 8'd5;
        bus.dec_wr_data = 12'h123;
        bus.dec_rd_addr = 8'd7;
        #1;
        check("m1_wr_en", {31'd0, bus.m1_wr_en}, 32'd1);
        check("m1_wr_addr", {24'd0, bus.m1_wr_addr}, 32'd5);
        check("m1_wr_data", {20'd0, bus.m1_wr_data}, 32'h123);
        check("m0_wr_quiet", {bus.m0_wr_en, 11'd0, bus.m0_wr_data, bus.m0_wr_addr}, 32'd0);
        check("m1_rd_addr", {24'd0, bus.m1_rd_addr}, 32'd7);
        tick();
        check("rd_latency", {24'd0, bus.dec_rd_data}, {24'd0, f1(8'd7)});
        bus.dec_wr_en = 1'b0;
        finish_job(2'b10);
        tick();

        // Reset while running aborts immediately; next request restarts cleanly
        wait_start(2'b10);
        tick();
        bus.dec_wr_en = 1'b1;
        #1;
        check("pre_rst_wr", {31'd0, bus.m1_wr_en}, 32'd1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_outs", {27'd0, bus.req_grant, bus.dec_start, bus.dec_cfg_sel, bus.m1_wr_en}, 32'd0);
        check("mid_rst_done", {30'd0, bus.req_done}, 32'd0);
        bus.dec_wr_en = 1'b0;
        rst_n = 1'b1;
        wait_start(2'b10);
        tick();
        finish_job(2'b10);
        bus.req_valid = 2'b00;
        tick();

        // Decoder never finishes
        bus.req_valid = 2'b01;
        wait_start(2'b01);
        bus.req_valid = 2'b00;
        bus.dec_wr_en = 1'b1;
`ifdef DECODE_ARB_WDOG_EN
        exp_q.push_back(4'b0101);
        tick();
        check("wdog_run_wr", {31'd0, bus.m0_wr_en}, 32'd1);
        wait_done(1, WDOG_CYC + 1, WDOG_CYC + 20);
        check("wdog_wr_block", {31'd0, bus.m0_wr_en}, 32'd0);
`else
        seen = 2'b00;
        repeat (200) begin
            tick();
            seen = seen | bus.req_done | bus.req_err;
        end
        check("no_completion", {30'd0, seen}, 32'd0);
        check("still_granted", {30'd0, bus.req_grant}, 32'd1);
`endif
        bus.dec_wr_en = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
